// File: rtl/pipeline_catch_buffer.sv
// pipeline_catch_buffer
//
// Credit-managed catch buffer that sits directly behind a fixed-latency,
// non-stallable delay pipeline. A launch credit is reserved when an element
// enters the pipeline, so there is always a free slot waiting for it when it
// emerges. Elements are captured into a small FIFO and presented on a
// valid/ready output.
//
// Ports:
//   clk           clock
//   arst_n        synchronous active-low reset, sampled on rising clk
//   launch_valid  upstream wants to inject one element into the pipeline
//   launch_ready  a credit is available; launch fires on valid & ready
//   pipe_valid    element emerging from the pipeline this cycle
//   pipe_data     pipeline output data
//   out_valid     buffer holds at least one element
//   out_ready     consumer accepts; pop fires on valid & ready
//   out_data      head element (zero when empty)
//   occupancy     elements currently stored
//   credits       DEPTH minus reserved slots
//   overflow_err  sticky: pipe_valid arrived while full with no pop
//   inflight_err  sticky: pipe_valid arrived with nothing in flight
module pipeline_catch_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  launch_valid,
    output logic                  launch_ready,
    input  logic                  pipe_valid,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      credits,
    output logic                  overflow_err,
    output logic                  inflight_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      r_reserved;
    logic                  r_overflow_err;
    logic                  r_inflight_err;

    logic w_launch_fire;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_overflow;
    logic w_no_inflight;

    // Pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        launch_ready  = arst_n & (r_reserved != C_DEPTH);
        out_valid     = arst_n & (r_count != '0);
        out_data      = out_valid ? r_mem[r_rd_ptr] : '0;
        occupancy     = r_count;
        credits       = C_DEPTH - r_reserved;
        overflow_err  = r_overflow_err;
        inflight_err  = r_inflight_err;

        w_launch_fire = launch_valid & launch_ready;
        w_pop         = out_valid & out_ready;
        w_full        = (r_count == C_DEPTH);
        // A full buffer still accepts when the head leaves at the same edge.
        w_push        = arst_n & pipe_valid & (~w_full | w_pop);
        w_overflow    = pipe_valid & w_full & ~w_pop;
        // An illegal push can leave count above reserved, so treat any
        // reserved <= count as "nothing in flight" rather than testing equality.
        w_no_inflight = (r_reserved <= r_count);
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_reserved     <= '0;
            r_overflow_err <= 1'b0;
            r_inflight_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Popping an element that was stored without a reservation would
            // otherwise underflow the reservation count, so it saturates at zero.
            if (w_launch_fire && !w_pop) begin
                r_reserved <= r_reserved + CNT_W'(1);
            end else if (!w_launch_fire && w_pop && (r_reserved != '0)) begin
                r_reserved <= r_reserved - CNT_W'(1);
            end

            if (w_overflow) begin
                r_overflow_err <= 1'b1;
            end
            if (pipe_valid && w_no_inflight) begin
                r_inflight_err <= 1'b1;
            end
        end
    end

    // Storage is not reset; out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pipe_data;
        end
    end

endmodule

// File: tb/tb_pipeline_catch_buffer.sv
// Testbench for pipeline_catch_buffer.
// Instance A: DEPTH=4, instance B: DEPTH=3; both behind a 2-cycle model pipeline.
// Expected outputs are queued at launch time and compared by a monitor on pop.
module tb_pipeline_catch_buffer;

    localparam int DW  = 32;
    localparam int DA  = 4;
    localparam int DB  = 3;
    localparam int CWA = $clog2(DA + 1);
    localparam int CWB = $clog2(DB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n = 1'b0;

    logic           a_lv = 1'b0, a_lr, a_pv = 1'b0, a_ov, a_or = 1'b0, a_oerr, a_ierr;
    logic [DW-1:0]  a_pd = '0, a_od, a_ld = '0;
    logic [CWA-1:0] a_occ, a_cred;

    logic           b_lv = 1'b0, b_lr, b_pv = 1'b0, b_ov, b_or = 1'b0, b_oerr, b_ierr;
    logic [DW-1:0]  b_pd = '0, b_od, b_ld = '0;
    logic [CWB-1:0] b_occ, b_cred;

    pipeline_catch_buffer #(.DATA_WIDTH(DW), .DEPTH(DA)) u_dut_a (
        .clk(clk), .arst_n(arst_n),
        .launch_valid(a_lv), .launch_ready(a_lr),
        .pipe_valid(a_pv), .pipe_data(a_pd),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .occupancy(a_occ), .credits(a_cred),
        .overflow_err(a_oerr), .inflight_err(a_ierr)
    );

    pipeline_catch_buffer #(.DATA_WIDTH(DW), .DEPTH(DB)) u_dut_b (
        .clk(clk), .arst_n(arst_n),
        .launch_valid(b_lv), .launch_ready(b_lr),
        .pipe_valid(b_pv), .pipe_data(b_pd),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .occupancy(b_occ), .credits(b_cred),
        .overflow_err(b_oerr), .inflight_err(b_ierr)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int b_npop = 0;

    logic [DW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];

    // Two-stage model pipeline per instance.
    logic          a_p0v = 1'b0, a_p1v = 1'b0, b_p0v = 1'b0, b_p1v = 1'b0;
    logic [DW-1:0] a_p0d = '0, a_p1d = '0, b_p0d = '0, b_p1d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every pop against the scoreboard.
    always @(negedge clk) begin
        if (arst_n && a_ov && a_or) begin
            if (a_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_pop_unexpected: got 0x%0h, expected no output", a_od);
            end else begin
                chk("a_pop_data", a_od, a_q.pop_front());
            end
        end
        if (arst_n && b_ov && b_or) begin
            b_npop++;
            if (b_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_pop_unexpected: got 0x%0h, expected no output", b_od);
            end else begin
                chk("b_pop_data", b_od, b_q.pop_front());
            end
        end
    end

    // One clock: record launches, advance the model pipelines, bump launch data.
    task automatic tick();
        logic fa, fb;
        fa = a_lv && a_lr;
        fb = b_lv && b_lr;
        if (fa) a_q.push_back(a_ld);
        if (fb) b_q.push_back(b_ld);
        @(posedge clk);
        #1;
        a_p1v = a_p0v; a_p1d = a_p0d; a_p0v = fa; a_p0d = a_ld;
        b_p1v = b_p0v; b_p1d = b_p0d; b_p0v = fb; b_p0d = b_ld;
        a_pv = a_p1v; a_pd = a_p1d;
        b_pv = b_p1v; b_pd = b_p1d;
        if (fa) a_ld = a_ld + 1;
        if (fb) b_ld = b_ld + 1;
    endtask

    task automatic drain_a(input string name);
        int guard;
        guard = 0;
        a_or = 1'b1;
        while ((a_q.size() != 0 || a_pv || a_p0v || a_p1v) && guard < 40) begin
            tick();
            guard++;
        end
        chk({name, "_drained"}, a_q.size(), 0);
        a_or = 1'b0;
    endtask

    initial begin
        int nl;
        int guard;

        // Reset held 3 cycles with launch_valid asserted.
        arst_n = 1'b0;
        a_lv   = 1'b1;
        repeat (3) tick();
        chk("rst_launch_ready", a_lr, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_credits", a_cred, DA);
        chk("rst_occupancy", a_occ, 0);
        a_lv   = 1'b0;
        arst_n = 1'b1;
        #1;
        chk("rel_launch_ready", a_lr, 1);
        chk("rel_occupancy", a_occ, 0);

        // Fill with out_ready=0: exactly DEPTH launches.
        a_ld = 32'hA0;
        a_lv = 1'b1;
        nl   = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_lv && a_lr) nl++;
            tick();
            if (i == 3) chk("fill_lr_low", a_lr, 0);
        end
        a_lv = 1'b0;
        repeat (2) tick();
        chk("fill_launches", nl, DA);
        chk("fill_occupancy", a_occ, DA);
        chk("fill_head", a_od, 32'hA0);
        chk("fill_credits", a_cred, 0);
        chk("fill_out_valid", a_ov, 1);
        chk("fill_errs", {a_oerr, a_ierr}, 0);
        drain_a("fill");
        chk("fill_credits_back", a_cred, DA);

        // Streaming at one launch per cycle.
        a_ld = 32'h100;
        a_or = 1'b1;
        a_lv = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("stream_lr", a_lr, 1);
            tick();
            chk("stream_out_valid", a_ov, (i >= 2) ? 1 : 0);
            if (i >= 2) chk("stream_credits", a_cred, 1);
        end
        a_lv = 1'b0;
        drain_a("stream");

        // Wrap test on DEPTH=3 with random consumer stalls.
        b_ld  = 32'h300;
        nl    = 0;
        guard = 0;
        while (nl < 20 && guard < 300) begin
            b_lv = 1'b1;
            b_or = 1'($urandom_range(0, 1));
            if (b_lv && b_lr) nl++;
            tick();
            chk("b_occ_max", (b_occ <= DB) ? 1 : 0, 1);
            guard++;
        end
        b_lv = 1'b0;
        chk("b_launches", nl, 20);
        b_or  = 1'b1;
        guard = 0;
        while ((b_q.size() != 0 || b_pv || b_p0v || b_p1v) && guard < 40) begin
            tick();
            guard++;
        end
        b_or = 1'b0;
        chk("b_pops", b_npop, 20);
        chk("b_errs", {b_oerr, b_ierr}, 0);

        // Stray pipe_valid with nothing in flight: stored, flagged.
        a_pv = 1'b1;
        a_pd = 32'h55;
        a_q.push_back(32'h55);
        tick();
        chk("inflight_err", a_ierr, 1);
        chk("inflight_occ", a_occ, 1);
        chk("inflight_head", a_od, 32'h55);
        chk("inflight_credits", a_cred, DA);
        chk("inflight_no_ovf", a_oerr, 0);
        drain_a("inflight");
        chk("inflight_credits_after", a_cred, DA);

        // Overflow: push while full with no pop is dropped.
        a_ld = 32'hC0;
        a_lv = 1'b1;
        repeat (6) tick();
        a_lv = 1'b0;
        repeat (2) tick();
        chk("ovf_pre_occ", a_occ, DA);
        a_pv = 1'b1;
        a_pd = 32'hEE;
        tick();
        chk("overflow_err", a_oerr, 1);
        chk("ovf_occ", a_occ, DA);
        chk("ovf_head", a_od, 32'hC0);
        drain_a("ovf");

        // Reset mid-operation: 3 stored, 1 in flight.
        a_ld = 32'hD0;
        a_lv = 1'b1;
        repeat (4) tick();
        a_lv = 1'b0;
        tick();
        chk("mid_occ", a_occ, 3);
        chk("mid_pipe_busy", a_pv, 1);
        arst_n = 1'b0;
        a_q.delete();
        tick();
        arst_n = 1'b1;
        #1;
        chk("mid_occ_clr", a_occ, 0);
        chk("mid_credits", a_cred, DA);
        chk("mid_out_valid", a_ov, 0);
        chk("mid_flags", {a_oerr, a_ierr}, 0);
        chk("mid_lr", a_lr, 1);
        a_pv = 1'b1;
        a_pd = 32'h77;
        a_q.push_back(32'h77);
        tick();
        chk("late_inflight_err", a_ierr, 1);
        drain_a("late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
